// File: rtl/simon_ctrl.sv
// Register bank and load/round/capture sequencer for an iterative Simon 64/96 round core.
// Optional macro SIMON_CTRL_TRIG_ROUND0_EN narrows trigger to LOAD plus the first round.
module simon_ctrl #(
   parameter int unsigned NROUNDS = 42,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       bus_we,
   input  logic [ADDR_W-1:0]          bus_addr,
   input  logic [7:0]                 bus_wdata,
   output logic [7:0]                 bus_rdata,
   output logic                       dp_load,
   output logic                       dp_round_en,
   output logic [$clog2(NROUNDS)-1:0] dp_round_idx,
   output logic [63:0]                dp_ptext,
   output logic [95:0]                dp_key,
   input  logic [63:0]                dp_state,
   output logic                       trigger,
   output logic                       busy
);

   localparam int unsigned IDX_W = $clog2(NROUNDS);
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NROUNDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(8'h14);
   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8'h20);

   typedef enum logic [1:0] {StIdle, StLoad, StRound, StCapture} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] round_idx_q;
   logic [63:0]      ptext_q;
   logic [95:0]      key_q;
   logic [63:0]      cipher_q;
   logic             done_q;
   logic             start_acc;

   // Only an idle controller accepts START; a write with bit 0 clear is a no-op.
   assign start_acc = (state_q == StIdle) && bus_we && (bus_addr == ADDR_START) && bus_wdata[0];

   always_comb begin
      state_d     = state_q;
      dp_load     = 1'b0;
      dp_round_en = 1'b0;
      trigger     = 1'b0;
      busy        = (state_q != StIdle);
      case (state_q)
         StIdle: begin
            if (start_acc) state_d = StLoad;
         end
         StLoad: begin
            dp_load = 1'b1;
            trigger = 1'b1;
            state_d = StRound;
         end
         StRound: begin
            dp_round_en = 1'b1;
`ifdef SIMON_CTRL_TRIG_ROUND0_EN
            trigger = (round_idx_q == '0);
`else
            trigger = 1'b1;
`endif
            if (round_idx_q == LAST_IDX) state_d = StCapture;
         end
         StCapture: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         round_idx_q <= '0;
         done_q      <= 1'b0;
         cipher_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            round_idx_q <= '0;
            done_q      <= 1'b0;
         end else if (state_q == StRound && round_idx_q != LAST_IDX) begin
            round_idx_q <= round_idx_q + IDX_W'(1);
         end
         if (state_q == StCapture) begin
            cipher_q <= dp_state;
            done_q   <= 1'b1;
         end
      end
   end

   // Operand registers are frozen for the whole run so the core sees stable inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptext_q <= '0;
         key_q   <= '0;
      end else if (state_q == StIdle && bus_we) begin
         for (int i = 0; i < 8; i++) begin
            if (bus_addr == ADDR_W'(i)) ptext_q[8*i +: 8] <= bus_wdata;
         end
         for (int i = 0; i < 12; i++) begin
            if (bus_addr == ADDR_W'(8 + i)) key_q[8*i +: 8] <= bus_wdata;
         end
      end
   end

   always_comb begin
      bus_rdata = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (bus_addr == ADDR_W'(i))         bus_rdata = ptext_q[8*i +: 8];
         if (bus_addr == ADDR_W'(8'h18 + i)) bus_rdata = cipher_q[8*i +: 8];
      end
      for (int i = 0; i < 12; i++) begin
         if (bus_addr == ADDR_W'(8 + i)) bus_rdata = key_q[8*i +: 8];
      end
      if (bus_addr == ADDR_STATUS) bus_rdata = {6'b0, done_q, busy};
   end

   assign dp_round_idx = round_idx_q;
   assign dp_ptext     = ptext_q;
   assign dp_key       = key_q;

endmodule

// File: tb/tb_simon_ctrl.sv
// Self-checking bench for simon_ctrl with a behavioural Simon 64/96 round core on dp_*
// and a phase-counter reference model compared on every falling edge.
module tb_simon_ctrl;

   localparam int NR = 42;
   localparam logic [61:0]  Z2      = 62'h3369F885192C0EF5;
   localparam logic [63:0]  KAT_PT  = 64'h6f7220676e696c63;
   localparam logic [95:0]  KAT_KEY = 96'h131211100b0a090803020100;
   localparam logic [63:0]  KAT_CT  = 64'h5ca2e27f111a8fc8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        bus_we = 1'b0;
   logic [7:0]  bus_addr = 8'h00;
   logic [7:0]  bus_wdata = 8'h00;
   logic [7:0]  bus_rdata;
   logic        dp_load, dp_round_en, trigger, busy;
   logic [5:0]  dp_round_idx;
   logic [63:0] dp_ptext, dp_state;
   logic [95:0] dp_key;

   int total = 0;
   int bad = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   simon_ctrl #(.NROUNDS(NR), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .dp_load(dp_load),
      .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx), .dp_ptext(dp_ptext),
      .dp_key(dp_key), .dp_state(dp_state), .trigger(trigger), .busy(busy)
   );

   function automatic logic [31:0] rol32(logic [31:0] v, int r);
      return (v << r) | (v >> (32 - r));
   endfunction

   function automatic logic [31:0] ror32(logic [31:0] v, int r);
      return (v >> r) | (v << (32 - r));
   endfunction

   function automatic logic [31:0] simon_f(logic [31:0] x);
      return (rol32(x, 1) & rol32(x, 8)) ^ rol32(x, 2);
   endfunction

   function automatic logic [31:0] next_key(logic [31:0] k0, logic [31:0] k2, int zi);
      logic [31:0] t;
      t = ror32(k2, 3);
      t = t ^ ror32(t, 1);
      return ~k0 ^ t ^ {31'b0, Z2[zi]} ^ 32'd3;
   endfunction

   function automatic logic [63:0] simon_encrypt(logic [63:0] pt, logic [95:0] key);
      logic [31:0] k [NR];
      logic [31:0] x, y, t;
      k[0] = key[31:0];
      k[1] = key[63:32];
      k[2] = key[95:64];
      for (int i = 3; i < NR; i++) k[i] = next_key(k[i-3], k[i-1], i - 3);
      x = pt[63:32];
      y = pt[31:0];
      for (int r = 0; r < NR; r++) begin
         t = x;
         x = y ^ simon_f(t) ^ k[r];
         y = t;
      end
      return {x, y};
   endfunction

   // Iterative round core attached to the dp_* side.
   logic [31:0] cx, cy, ck0, ck1, ck2;
   assign dp_state = {cx, cy};
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         {cx, cy, ck0, ck1, ck2} <= '0;
      end else if (dp_load) begin
         {cx, cy}        <= dp_ptext;
         {ck2, ck1, ck0} <= dp_key;
      end else if (dp_round_en) begin
         cx  <= cy ^ simon_f(cx) ^ ck0;
         cy  <= cx;
         ck0 <= ck1;
         ck1 <= ck2;
         ck2 <= next_key(ck0, ck2, int'(dp_round_idx));
      end
   end

   // Reference model: phase -1 idle, 0 load, 1..NR rounds, NR+1 capture.
   int          phase = -1;
   int          m_idx = 0;
   logic [63:0] m_pt = '0, m_ct = '0;
   logic [95:0] m_key = '0;
   logic        m_done = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         phase = -1; m_idx = 0; m_pt = '0; m_ct = '0; m_key = '0; m_done = 1'b0;
      end else begin
         if (phase == NR + 1) begin
            m_ct   = simon_encrypt(m_pt, m_key);
            m_done = 1'b1;
         end
         if (phase < 0) begin
            if (bus_we) begin
               if (bus_addr < 8) m_pt[8*bus_addr +: 8] = bus_wdata;
               else if (bus_addr < 20) m_key[8*(bus_addr-8) +: 8] = bus_wdata;
               else if (bus_addr == 8'h14 && bus_wdata[0]) begin
                  phase = 0; m_idx = 0; m_done = 1'b0;
               end
            end
         end else begin
            phase++;
            if (phase > NR + 1) phase = -1;
            else if (phase <= NR) m_idx = phase - 1;
         end
      end
   end

   function automatic logic [7:0] m_read(logic [7:0] a);
      if (a < 8) return m_pt[8*a +: 8];
      if (a < 20) return m_key[8*(a-8) +: 8];
      if (a >= 8'h18 && a <= 8'h1f) return m_ct[8*(a-24) +: 8];
      if (a == 8'h20) return {6'b0, m_done, phase >= 0};
      return 8'h00;
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, phase >= 0);
         chk("dp_load", dp_load, phase == 0);
         chk("dp_round_en", dp_round_en, phase >= 1 && phase <= NR);
`ifdef SIMON_CTRL_TRIG_ROUND0_EN
         chk("trigger", trigger, phase == 0 || phase == 1);
`else
         chk("trigger", trigger, phase >= 0 && phase <= NR);
`endif
         chk("dp_round_idx", dp_round_idx, m_idx);
         chk("dp_ptext", dp_ptext, m_pt);
         chk("dp_key", dp_key, m_key);
         chk("bus_rdata", bus_rdata, m_read(bus_addr));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      cyc();
      bus_we = 1'b0;
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string nm);
      bus_addr = a;
      #1;
      chk(nm, bus_rdata, exp);
   endtask

   task automatic load_vec(input logic [63:0] pt, input logic [95:0] key);
      for (int i = 0; i < 12; i++) wr(8'(8 + i), key[8*i +: 8]);
      for (int i = 0; i < 8; i++) wr(8'(i), pt[8*i +: 8]);
   endtask

   task automatic read_ct(output logic [63:0] ct);
      for (int i = 0; i < 8; i++) begin
         cyc();
         bus_addr = 8'(24 + i);
         #1;
         ct[8*i +: 8] = bus_rdata;
      end
      cyc();
   endtask

   task automatic wait_idle(input int max, input string nm);
      int n = 0;
      while (busy && n < max) begin
         cyc();
         n++;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL %s: timeout, busy still %0b after %0d cycles", nm, busy, n);
      end
   endtask

   initial begin
      logic [63:0] ct, pt;
      logic [95:0] key;
      int bc, tc, n;

      #2 reset = 1'b1;
      cyc(); cyc();
      chk_en = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();

      // Reset state
      chk("rst_busy", busy, 1'b0);
      chk("rst_trigger", trigger, 1'b0);
      chk("rst_idx", dp_round_idx, 6'd0);
      rd_chk(8'h20, 8'h00, "rst_status");
      for (int i = 0; i < 8; i++) rd_chk(8'(24 + i), 8'h00, "rst_cipher");
      chk("model_kat", simon_encrypt(KAT_PT, KAT_KEY), KAT_CT);

      // Known-answer run with busy/trigger widths
      cyc();
      load_vec(KAT_PT, KAT_KEY);
      wr(8'h14, 8'h01);
      bc = 0; tc = 0; n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (busy) bc++;
         if (trigger) tc++;
         n++;
         if (!busy) break;
      end
      cyc();
      chk("busy_width", bc, 44);
`ifdef SIMON_CTRL_TRIG_ROUND0_EN
      chk("trigger_width", tc, 2);
`else
      chk("trigger_width", tc, 43);
`endif
      read_ct(ct);
      chk("kat_cipher", ct, KAT_CT);
      rd_chk(8'h20, 8'h02, "kat_status");

      // START and PTEXT writes while busy are ignored
      cyc();
      wr(8'h14, 8'h01);
      repeat (10) cyc();
      wr(8'h14, 8'h01);
      wr(8'h00, 8'hff);
      wait_idle(100, "midrun_wait");
      read_ct(ct);
      chk("midrun_cipher", ct, KAT_CT);
      rd_chk(8'h00, 8'h63, "midrun_ptext0");

      // Reset in the middle of a run
      cyc();
      wr(8'h14, 8'h01);
      repeat (21) cyc();
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_trigger", trigger, 1'b0);
      rd_chk(8'h20, 8'h00, "midrst_status");
      for (int i = 0; i < 8; i++) rd_chk(8'(24 + i), 8'h00, "midrst_cipher");
      cyc();
      reset = 1'b0;
      cyc();
      load_vec(KAT_PT, KAT_KEY);
      wr(8'h14, 8'h01);
      wait_idle(100, "postrst_wait");
      read_ct(ct);
      chk("postrst_cipher", ct, KAT_CT);

      // Unmapped reads and START writes without bit 0
      rd_chk(8'h15, 8'h00, "read_0x15");
      rd_chk(8'h21, 8'h00, "read_0x21");
      cyc();
      wr(8'h14, 8'h00);
      cyc();
      chk("start0_idle", busy, 1'b0);
      wr(8'h14, 8'h02);
      cyc();
      chk("start2_idle", busy, 1'b0);

      // Back-to-back random runs with random bus traffic while busy
      for (int r = 0; r < 20; r++) begin
         pt  = {$urandom, $urandom};
         key = {$urandom, $urandom, $urandom};
         load_vec(pt, key);
         wr(8'h14, 8'h01);
         n = 0;
         while (busy && n < 100) begin
            bus_we    = ($urandom_range(0, 1) == 1);
            bus_addr  = 8'($urandom_range(0, 33));
            bus_wdata = 8'($urandom);
            cyc();
            n++;
         end
         bus_we = 1'b0;
         if (busy) begin
            total++; bad++;
            $display("FAIL rand_wait: timeout in run %0d", r);
         end
         read_ct(ct);
         chk("rand_cipher", ct, simon_encrypt(pt, key));
      end

      cyc();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
